// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a valid/ready byte stream with preamble, SFD, zero padding,
// CRC-32 FCS and inter-frame gap. One byte per clock; txd/txen/txer are registered.
module gmii_tx_framer #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_FRAME    = 60,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic       user_clk,
  input  logic       reset,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  input  logic       s_tuser,
  output logic       s_tready,
  output logic [7:0] txd,
  output logic       txen,
  output logic       txer,
  output logic       frame_done,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    StIdle, StPre, StSfd, StData, StPad, StFcs, StDrain, StIfg
  } state_e;

  state_e      r_state, w_state;
  logic [10:0] r_cnt, w_cnt, w_cnt_inc;
  logic [15:0] r_ifg_cnt, w_ifg_cnt;
  logic [31:0] r_crc, w_crc;
  logic [7:0]  r_txd, w_txd;
  logic        r_txen, w_txen, r_txer, w_txer;
  logic        r_done_pend, w_done_pend, r_frame_done, r_frame_err, w_frame_err;
  logic        w_xfer;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign s_tready  = (r_state == StSfd) || (r_state == StData) || (r_state == StDrain);
  assign w_xfer    = s_tvalid & s_tready;
  assign w_cnt_inc = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;

  // Output registers are loaded with what the next cycle must show on the wire.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_ifg_cnt   = (r_ifg_cnt != '0) ? r_ifg_cnt - 16'd1 : '0;
    w_crc       = r_crc;
    w_txd       = 8'h00;
    w_txen      = 1'b0;
    w_txer      = 1'b0;
    w_done_pend = 1'b0;
    w_frame_err = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (s_tvalid) begin
          w_state = StPre;
          w_cnt   = '0;
          w_txd   = 8'h55;
          w_txen  = 1'b1;
        end
      end
      StPre: begin
        w_txen = 1'b1;
        if (r_cnt == 11'(PREAMBLE_LEN - 1)) begin
          w_state = StSfd;
          w_txd   = 8'hD5;
          w_cnt   = '0;
          w_crc   = 32'hFFFF_FFFF;
        end else begin
          w_txd = 8'h55;
          w_cnt = r_cnt + 11'd1;
        end
      end
      StSfd, StData: begin
        w_txen = 1'b1;
        if (w_xfer) begin
          w_state = StData;
          w_txd   = s_tdata;
          w_crc   = crc_byte(r_crc, s_tdata);
          w_cnt   = w_cnt_inc;
          if (s_tlast) begin
            if (s_tuser) begin
              w_txer      = 1'b1;
              w_frame_err = 1'b1;
              w_state     = StIfg;
              w_ifg_cnt   = 16'(IFG_BYTES - 1);
            end else if (32'(w_cnt_inc) < MIN_FRAME) begin
              w_state = StPad;
            end else begin
              w_state = StFcs;
              w_cnt   = '0;
            end
          end
        end else begin
          // Source starved mid-frame: flag the error on the wire and discard the rest.
          w_txer      = 1'b1;
          w_frame_err = 1'b1;
          w_state     = StDrain;
          w_ifg_cnt   = 16'(IFG_BYTES - 1);
        end
      end
      StPad: begin
        w_txen = 1'b1;
        w_crc  = crc_byte(r_crc, 8'h00);
        w_cnt  = w_cnt_inc;
        if (32'(w_cnt_inc) >= MIN_FRAME) begin
          w_state = StFcs;
          w_cnt   = '0;
        end
      end
      StFcs: begin
        w_txen = 1'b1;
        w_txd  = ~r_crc[7:0];
        w_crc  = {8'h00, r_crc[31:8]};
        w_cnt  = r_cnt + 11'd1;
        if (r_cnt == 11'd3) begin
          w_state     = StIfg;
          w_ifg_cnt   = 16'(IFG_BYTES - 1);
          w_done_pend = 1'b1;
        end
      end
      StDrain: begin
        if (w_xfer && s_tlast) w_state = (r_ifg_cnt == '0) ? StIdle : StIfg;
      end
      StIfg: begin
        if (r_ifg_cnt == '0) w_state = StIdle;
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_ifg_cnt    <= '0;
      r_crc        <= 32'hFFFF_FFFF;
      r_txd        <= '0;
      r_txen       <= 1'b0;
      r_txer       <= 1'b0;
      r_done_pend  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_ifg_cnt    <= w_ifg_cnt;
      r_crc        <= w_crc;
      r_txd        <= w_txd;
      r_txen       <= w_txen;
      r_txer       <= w_txer;
      r_done_pend  <= w_done_pend;
      r_frame_done <= r_done_pend;
      r_frame_err  <= w_frame_err;
    end
  end

  assign txd        = r_txd;
  assign txen       = r_txen;
  assign txer       = r_txer;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Self-checking bench for gmii_tx_framer: expected wire bytes are queued from a reference
// model when a frame is driven and popped as txen bursts appear on the GMII side.
module tb_gmii_tx_framer;
  typedef logic [7:0] bq_t[$];
  typedef logic [8:0] wq_t[$];

  logic       user_clk = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] s_tdata  = 8'h00;
  logic       s_tvalid = 1'b0;
  logic       s_tlast  = 1'b0;
  logic       s_tuser  = 1'b0;
  logic       sel      = 1'b0;

  logic       rdy_a, txen_a, txer_a, done_a, err_a;
  logic       rdy_b, txen_b, txer_b, done_b, err_b;
  logic [7:0] txd_a, txd_b;
  logic       m_rdy, m_txen, m_txer, m_done, m_err;
  logic [7:0] m_txd;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;
  int n_err   = 0;
  wq_t exp_q;

  always #5 user_clk = ~user_clk;

  gmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(60), .IFG_BYTES(12)) u_dut (
    .user_clk(user_clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tready(rdy_a), .txd(txd_a), .txen(txen_a),
    .txer(txer_a), .frame_done(done_a), .frame_err(err_a)
  );

  gmii_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(0), .IFG_BYTES(12)) u_dut_nopad (
    .user_clk(user_clk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tuser(s_tuser), .s_tready(rdy_b), .txd(txd_b), .txen(txen_b),
    .txer(txer_b), .frame_done(done_b), .frame_err(err_b)
  );

  assign m_rdy  = sel ? rdy_b  : rdy_a;
  assign m_txd  = sel ? txd_b  : txd_a;
  assign m_txen = sel ? txen_b : txen_a;
  assign m_txer = sel ? txer_b : txer_a;
  assign m_done = sel ? done_b : done_a;
  assign m_err  = sel ? err_b  : err_a;

  always @(negedge user_clk) begin
    if (m_done) n_done++;
    if (m_err) n_err++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  // Bit-serial reflected CRC-32, independent of the byte-wise form.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++) begin
      if (x[0] ^ b[i]) x = {1'b0, x[31:1]} ^ 32'hEDB8_8320;
      else x = {1'b0, x[31:1]};
    end
    return x;
  endfunction

  // Reference model: queue the {txer,txd} bytes one frame must produce while txen is high.
  task automatic push_expected(input bq_t d, input int minf, input bit abort, input int drop_at);
    logic [31:0] c;
    logic [31:0] f;
    int n;
    c = 32'hFFFF_FFFF;
    n = 0;
    repeat (7) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    for (int i = 0; i < d.size(); i++) begin
      if (i == drop_at) begin
        exp_q.push_back({1'b1, 8'h00});
        return;
      end
      if (abort && i == d.size() - 1) begin
        exp_q.push_back({1'b1, d[i]});
        return;
      end
      exp_q.push_back({1'b0, d[i]});
      c = crc_step(c, d[i]);
      n++;
    end
    while (n < minf) begin
      exp_q.push_back(9'h000);
      c = crc_step(c, 8'h00);
      n++;
    end
    f = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, f[8*k +: 8]});
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge user_clk);
    while (!m_rdy && k < 500) begin
      k++;
      @(negedge user_clk);
    end
  endtask

  task automatic drive_frame(input bq_t d, input int drop_at, input bit abort);
    for (int i = 0; i < d.size(); i++) begin
      if (i == drop_at) begin
        s_tvalid = 1'b0;
        wait_ready();
        @(posedge user_clk);
        #1;
      end
      s_tdata  = d[i];
      s_tvalid = 1'b1;
      s_tlast  = (i == d.size() - 1);
      s_tuser  = abort && (i == d.size() - 1);
      wait_ready();
      @(posedge user_clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    s_tdata  = 8'h00;
  endtask

  // Called at a negedge; counts idle cycles, then records one txen burst.
  task automatic capture_burst(output wq_t obs, output int gap, output bit done_end,
                               output bit to);
    int len;
    obs.delete();
    gap = 0;
    len = 0;
    to = 1'b0;
    done_end = 1'b0;
    while (!m_txen) begin
      gap++;
      if (gap > 400) begin
        to = 1'b1;
        return;
      end
      @(negedge user_clk);
    end
    while (m_txen) begin
      obs.push_back({m_txer, m_txd});
      len++;
      if (len > 3000) begin
        to = 1'b1;
        return;
      end
      @(negedge user_clk);
    end
    done_end = m_done;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge user_clk);
    @(negedge user_clk);
    n_total += 6;
    if (m_txen !== 1'b0) begin n_bad++; $display("FAIL rst_txen: got %b want 0", m_txen); end
    if (m_txer !== 1'b0) begin n_bad++; $display("FAIL rst_txer: got %b want 0", m_txer); end
    if (m_txd !== 8'h00) begin n_bad++; $display("FAIL rst_txd: got %h want 00", m_txd); end
    if (m_rdy !== 1'b0) begin n_bad++; $display("FAIL rst_rdy: got %b want 0", m_rdy); end
    if (m_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", m_done); end
    if (m_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", m_err); end
    @(posedge user_clk);
    #1 reset = 1'b0;
    repeat (4) @(negedge user_clk);
    n_total += 2;
    if (m_txen !== 1'b0) begin n_bad++; $display("FAIL idle_txen: got %b want 0", m_txen); end
    if (m_rdy !== 1'b0) begin n_bad++; $display("FAIL idle_rdy: got %b want 0", m_rdy); end
  endtask

  task automatic test_crc_vector();
    bq_t d;
    bq_t fcs_k;
    wq_t obs;
    int gap;
    bit de, to;
    logic [8:0] w;
    fcs_k = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    for (int i = 0; i < 9; i++) d.push_back(8'h31 + 8'(i));
    sel = 1'b1;
    push_expected(d, 0, 1'b0, -1);
    @(negedge user_clk);
    fork
      drive_frame(d, -1, 1'b0);
      capture_burst(obs, gap, de, to);
    join
    n_total += 2;
    if (to !== 1'b0) begin n_bad++; $display("FAIL crc_timeout: got %b want 0", to); end
    if (obs.size() != 21) begin
      n_bad++;
      $display("FAIL crc_len: got %0d want 21", obs.size());
    end
    for (int i = 0; i < obs.size(); i++) begin
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      n_total++;
      if (obs[i] !== w) begin n_bad++; $display("FAIL crc_byte[%0d]: got %h want %h", i, obs[i], w); end
      if (i >= 17 && i < 21) begin
        n_total++;
        if (obs[i][7:0] !== fcs_k[i-17]) begin
          n_bad++;
          $display("FAIL crc_fcs[%0d]: got %h want %h", i - 17, obs[i][7:0], fcs_k[i-17]);
        end
      end
    end
    exp_q.delete();
    repeat (80) @(negedge user_clk);
    sel = 1'b0;
  endtask

  task automatic test_frame64();
    bq_t d;
    wq_t obs;
    int gap, d0, e0;
    bit de, to;
    logic [8:0] w;
    logic [31:0] c;
    for (int i = 0; i < 64; i++) d.push_back(8'(i));
    push_expected(d, 60, 1'b0, -1);
    d0 = n_done;
    e0 = n_err;
    @(negedge user_clk);
    fork
      drive_frame(d, -1, 1'b0);
      capture_burst(obs, gap, de, to);
    join
    repeat (3) @(negedge user_clk);
    n_total += 5;
    if (to !== 1'b0) begin n_bad++; $display("FAIL f64_timeout: got %b want 0", to); end
    if (obs.size() != 76) begin n_bad++; $display("FAIL f64_len: got %0d want 76", obs.size()); end
    if (de !== 1'b1) begin n_bad++; $display("FAIL f64_done_at_end: got %b want 1", de); end
    if (n_done - d0 != 1) begin n_bad++; $display("FAIL f64_done_cnt: got %0d want 1", n_done - d0); end
    if (n_err != e0) begin n_bad++; $display("FAIL f64_err_cnt: got %0d want 0", n_err - e0); end
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < obs.size(); i++) c = crc_step(c, obs[i][7:0]);
    n_total++;
    if (c !== 32'hDEBB_20E3) begin n_bad++; $display("FAIL f64_residue: got %h want debb20e3", c); end
    for (int i = 0; i < obs.size(); i++) begin
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      n_total++;
      if (obs[i] !== w) begin n_bad++; $display("FAIL f64_byte[%0d]: got %h want %h", i, obs[i], w); end
    end
    exp_q.delete();
    repeat (20) @(negedge user_clk);
  endtask

  task automatic test_pad();
    bq_t d;
    wq_t obs;
    int gap, zeros;
    bit de, to;
    logic [8:0] w;
    for (int i = 0; i < 9; i++) d.push_back(8'hA0 + 8'(i));
    push_expected(d, 60, 1'b0, -1);
    @(negedge user_clk);
    fork
      drive_frame(d, -1, 1'b0);
      capture_burst(obs, gap, de, to);
    join
    zeros = 0;
    for (int i = 17; i < 68 && i < obs.size(); i++) if (obs[i] === 9'h000) zeros++;
    n_total += 3;
    if (to !== 1'b0) begin n_bad++; $display("FAIL pad_timeout: got %b want 0", to); end
    if (obs.size() != 72) begin n_bad++; $display("FAIL pad_len: got %0d want 72", obs.size()); end
    if (zeros != 51) begin n_bad++; $display("FAIL pad_zeros: got %0d want 51", zeros); end
    for (int i = 0; i < obs.size(); i++) begin
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      n_total++;
      if (obs[i] !== w) begin n_bad++; $display("FAIL pad_byte[%0d]: got %h want %h", i, obs[i], w); end
    end
    exp_q.delete();
    repeat (20) @(negedge user_clk);
  endtask

  // Two frames presented with no idle on the source side; also reused for the error cases.
  task automatic run_pair(input string tag, input bq_t d1, input int drop_at, input bit abort,
                          input int len1, input bit exact_gap);
    bq_t d2;
    wq_t o1, o2;
    int g1, g2, d0, e0;
    bit de1, de2, to1, to2;
    logic [8:0] w;
    for (int i = 0; i < 20; i++) d2.push_back(8'h80 + 8'(i));
    push_expected(d1, 60, abort, drop_at);
    push_expected(d2, 60, 1'b0, -1);
    d0 = n_done;
    e0 = n_err;
    @(negedge user_clk);
    fork
      begin
        drive_frame(d1, drop_at, abort);
        drive_frame(d2, -1, 1'b0);
      end
      begin
        capture_burst(o1, g1, de1, to1);
        capture_burst(o2, g2, de2, to2);
      end
    join
    repeat (3) @(negedge user_clk);
    n_total += 6;
    if (to1 | to2) begin n_bad++; $display("FAIL %s_timeout: got %b%b want 00", tag, to1, to2); end
    if (o1.size() != len1) begin
      n_bad++;
      $display("FAIL %s_len1: got %0d want %0d", tag, o1.size(), len1);
    end
    if (exact_gap ? (g2 != 12) : (g2 < 12)) begin
      n_bad++;
      $display("FAIL %s_gap: got %0d want %s12", tag, g2, exact_gap ? "" : ">=");
    end
    if (de1 !== !(abort || drop_at >= 0)) begin
      n_bad++;
      $display("FAIL %s_done1: got %b want %b", tag, de1, !(abort || drop_at >= 0));
    end
    if (n_done - d0 != ((abort || drop_at >= 0) ? 1 : 2)) begin
      n_bad++;
      $display("FAIL %s_done_cnt: got %0d want %0d", tag, n_done - d0,
               (abort || drop_at >= 0) ? 1 : 2);
    end
    if (n_err - e0 != ((abort || drop_at >= 0) ? 1 : 0)) begin
      n_bad++;
      $display("FAIL %s_err_cnt: got %0d want %0d", tag, n_err - e0,
               (abort || drop_at >= 0) ? 1 : 0);
    end
    foreach (o2[i]) o1.push_back(o2[i]);
    for (int i = 0; i < o1.size(); i++) begin
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      n_total++;
      if (o1[i] !== w) begin n_bad++; $display("FAIL %s_byte[%0d]: got %h want %h", tag, i, o1[i], w); end
    end
    exp_q.delete();
    repeat (20) @(negedge user_clk);
  endtask

  task automatic test_back_to_back();
    bq_t d;
    for (int i = 0; i < 64; i++) d.push_back(8'hFF - 8'(i));
    run_pair("b2b", d, -1, 1'b0, 76, 1'b1);
  endtask

  task automatic test_underrun();
    bq_t d;
    for (int i = 0; i < 30; i++) d.push_back(8'h40 + 8'(i));
    run_pair("underrun", d, 20, 1'b0, 29, 1'b0);
  endtask

  task automatic test_abort();
    bq_t d;
    for (int i = 0; i < 100; i++) d.push_back(8'(i * 3));
    run_pair("abort", d, -1, 1'b1, 108, 1'b1);
  endtask

  task automatic test_reset_mid();
    bq_t d;
    wq_t obs;
    int gap, k;
    bit de, to;
    logic [8:0] w;
    s_tdata  = 8'h11;
    s_tvalid = 1'b1;
    k = 0;
    @(negedge user_clk);
    while (!m_txen && k < 50) begin
      k++;
      @(negedge user_clk);
    end
    repeat (20) @(negedge user_clk);
    n_total++;
    if (m_txen !== 1'b1) begin n_bad++; $display("FAIL rmid_active: got %b want 1", m_txen); end
    @(posedge user_clk);
    #1;
    reset    = 1'b1;
    s_tvalid = 1'b0;
    @(posedge user_clk);
    @(negedge user_clk);
    n_total += 3;
    if (m_txen !== 1'b0) begin n_bad++; $display("FAIL rmid_txen: got %b want 0", m_txen); end
    if (m_txer !== 1'b0) begin n_bad++; $display("FAIL rmid_txer: got %b want 0", m_txer); end
    if (m_rdy !== 1'b0) begin n_bad++; $display("FAIL rmid_rdy: got %b want 0", m_rdy); end
    @(posedge user_clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 12; i++) d.push_back(8'hC0 + 8'(i));
    push_expected(d, 60, 1'b0, -1);
    @(negedge user_clk);
    fork
      drive_frame(d, -1, 1'b0);
      capture_burst(obs, gap, de, to);
    join
    n_total += 2;
    if (to !== 1'b0) begin n_bad++; $display("FAIL rmid_timeout: got %b want 0", to); end
    if (obs.size() != 72) begin n_bad++; $display("FAIL rmid_len: got %0d want 72", obs.size()); end
    for (int i = 0; i < obs.size(); i++) begin
      w = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      n_total++;
      if (obs[i] !== w) begin n_bad++; $display("FAIL rmid_byte[%0d]: got %h want %h", i, obs[i], w); end
    end
    exp_q.delete();
    repeat (20) @(negedge user_clk);
  endtask

  initial begin
    test_reset();
    test_crc_vector();
    test_frame64();
    test_pad();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
